// File: rtl/ens_pkg.sv
// Shared constants, FSM encoding and pixel quantizer for ensemble 0 / layer 0.
package ens_pkg;

  localparam int unsigned NUM_PIXELS = 784;
  localparam int unsigned PIX_W      = 8;
  localparam int unsigned IN_BITS    = 1;
  localparam int unsigned FRAME_W    = NUM_PIXELS * IN_BITS;

  // Packer FSM states (legacy-compatible constant encoding)
  localparam logic ST_FILL    = 1'b0;
  localparam logic ST_DISCARD = 1'b1;

  // Truncating quantizer: keep the in_bits MSBs of a pix_w-wide unsigned pixel
  function automatic logic [31:0] quantize(input logic [31:0] pix,
                                           input int unsigned pix_w,
                                           input int unsigned in_bits);
    return pix >> (pix_w - in_bits);
  endfunction

endpackage

// File: rtl/ens0_frame_bank.sv
// One frame buffer: slot-addressed write port plus a full flag that qualifies the payload.
module ens0_frame_bank #(
  parameter int unsigned NUM_SLOTS = 784,
  parameter int unsigned SLOT_W    = 1,
  localparam int unsigned IDX_W    = $clog2(NUM_SLOTS),
  localparam int unsigned DATA_W   = NUM_SLOTS * SLOT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [SLOT_W-1:0] wdata,
  input  logic              set_full,
  input  logic              clr_full,
  output logic              full,
  output logic [DATA_W-1:0] data
);

  logic [DATA_W-1:0] data_q;
  logic              full_q;

  // Slot write; payload needs no reset because full_q gates its use
  always_ff @(posedge clk) begin
    if (we) begin
      data_q[int'(idx) * SLOT_W +: SLOT_W] <= wdata;
    end
  end

  // Full flag: set on commit, cleared when the consumer takes the frame
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
    end else if (set_full) begin
      full_q <= 1'b1;
    end else if (clr_full) begin
      full_q <= 1'b0;
    end
  end

  assign full = full_q;
  assign data = data_q;

endmodule

// File: rtl/ens0_input_packer.sv
// Pixel stream to packed, double-buffered frame for layer 0 of ensemble 0.
module ens0_input_packer
  import ens_pkg::ST_FILL, ens_pkg::ST_DISCARD, ens_pkg::quantize;
#(
  parameter int unsigned NUM_PIXELS = ens_pkg::NUM_PIXELS,
  parameter int unsigned PIX_W      = ens_pkg::PIX_W,
  parameter int unsigned IN_BITS    = ens_pkg::IN_BITS,
  localparam int unsigned FRAME_W   = NUM_PIXELS * IN_BITS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [PIX_W-1:0]   s_data,
  input  logic               s_last,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [FRAME_W-1:0] m_data,
  output logic               err_len
);

  localparam int unsigned      CNT_W    = $clog2(NUM_PIXELS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_PIXELS - 1);

  logic               state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               wsel_q, wsel_d;
  logic               rsel_q, rsel_d;
  logic               s_ready_q, s_ready_d;
  logic               err_q, err_d;
  logic [1:0]         full, full_nxt, we, set_full, clr_full;
  logic [FRAME_W-1:0] bank_data [2];
  logic [IN_BITS-1:0] qpix;
  logic               accept, consume;

  assign qpix    = IN_BITS'(quantize(32'(s_data), PIX_W, IN_BITS));
  assign accept  = s_valid && s_ready_q;
  assign consume = full[rsel_q] && m_ready;

  // Write side: slot write, frame-length policing and bank commit
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wsel_d   = wsel_q;
    err_d    = 1'b0;
    we       = '0;
    set_full = '0;
    if (accept) begin
      if (state_q == ST_DISCARD) begin
        if (s_last) state_d = ST_FILL;
      end else begin
        // A short frame also writes here; the bank is simply never committed
        we[wsel_q] = 1'b1;
        if (cnt_q == LAST_IDX) begin
          set_full[wsel_q] = 1'b1;
          wsel_d           = ~wsel_q;
          cnt_d            = '0;
          if (!s_last) begin
            err_d   = 1'b1;
            state_d = ST_DISCARD;
          end
        end else if (s_last) begin
          err_d = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  // Read side and registered ready, computed from next-cycle bank occupancy
  always_comb begin
    clr_full = '0;
    rsel_d   = rsel_q;
    if (consume) begin
      clr_full[rsel_q] = 1'b1;
      rsel_d           = ~rsel_q;
    end
    full_nxt  = (full | set_full) & ~clr_full;
    s_ready_d = (state_d == ST_DISCARD) || !full_nxt[wsel_d];
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_FILL;
      cnt_q     <= '0;
      wsel_q    <= 1'b0;
      rsel_q    <= 1'b0;
      s_ready_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wsel_q    <= wsel_d;
      rsel_q    <= rsel_d;
      s_ready_q <= s_ready_d;
      err_q     <= err_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    ens0_frame_bank #(
      .NUM_SLOTS (NUM_PIXELS),
      .SLOT_W    (IN_BITS)
    ) u_bank (
      .clk      (clk),
      .rst      (rst),
      .we       (we[b]),
      .idx      (cnt_q),
      .wdata    (qpix),
      .set_full (set_full[b]),
      .clr_full (clr_full[b]),
      .full     (full[b]),
      .data     (bank_data[b])
    );
  end

  assign s_ready = s_ready_q;
  assign m_valid = full[rsel_q];
  assign m_data  = bank_data[rsel_q];
  assign err_len = err_q;

endmodule

// File: tb/tb_ens0_input_packer.sv
// Self-checking bench: queue-of-frames reference model plus a 2-bit quantization table.
module tb_ens0_input_packer;
  import ens_pkg::*;

  localparam int NP = NUM_PIXELS;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic               s_valid, s_ready, s_last, m_valid, m_ready, err_len;
  logic [PIX_W-1:0]   s_data;
  logic [FRAME_W-1:0] m_data;

  logic       s2_valid, s2_ready, s2_last, m2_valid, m2_ready, err2;
  logic [7:0] s2_data;
  logic [7:0] m2_data;

  ens0_input_packer dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .err_len (err_len)
  );

  ens0_input_packer #(
    .NUM_PIXELS (4),
    .PIX_W      (8),
    .IN_BITS    (2)
  ) dut2 (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s2_valid),
    .s_ready (s2_ready),
    .s_data  (s2_data),
    .s_last  (s2_last),
    .m_valid (m2_valid),
    .m_ready (m2_ready),
    .m_data  (m2_data),
    .err_len (err2)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_print  = 0;
  int err_seen = 0;

  // Reference model: frames waiting for layer 0, image under construction, discard flag
  logic [FRAME_W-1:0] exp_q [$];
  logic [FRAME_W-1:0] cur;
  int                 cur_len = 0;
  bit                 discard = 0;
  bit                 exp_ready = 0;
  bit                 exp_err = 0;
  bit                 last_acc = 0;
  bit                 rand_mready = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else begin
      if (n_print < 40) $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      n_print++;
    end
  endtask

  task automatic chk_frame(input logic [FRAME_W-1:0] got, input logic [FRAME_W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else begin
      if (n_print < 40) $display("FAIL m_data: got %h expected %h", got, exp);
      n_print++;
    end
  endtask

  // Advance one clock: update the model from the inputs, then compare outputs after the edge
  task automatic step();
    bit acc, cons;
    if (rand_mready) m_ready = 1'($urandom_range(1));
    acc     = s_valid && exp_ready && !rst;
    cons    = m_ready && (exp_q.size() > 0);
    exp_err = 0;
    if (rst) begin
      exp_q.delete();
      cur_len   = 0;
      discard   = 0;
      exp_ready = 0;
    end else begin
      if (cons) void'(exp_q.pop_front());
      if (acc) begin
        if (discard) begin
          if (s_last) discard = 0;
        end else begin
          cur[cur_len] = (s_data >= 8'd128);
          cur_len++;
          if (cur_len == NP) begin
            exp_q.push_back(cur);
            cur_len = 0;
            if (!s_last) begin
              exp_err = 1;
              discard = 1;
            end
          end else if (s_last) begin
            exp_err = 1;
            cur_len = 0;
          end
        end
      end
      exp_ready = discard || (exp_q.size() < 2);
    end
    last_acc = acc;
    @(posedge clk);
    #1;
    chk("s_ready", 32'(s_ready), 32'(exp_ready));
    chk("m_valid", 32'(m_valid), 32'(exp_q.size() > 0));
    chk("err_len", 32'(err_len), 32'(exp_err));
    if (err_len === 1'b1) err_seen++;
    if (exp_q.size() > 0) chk_frame(m_data, exp_q[0]);
  endtask

  task automatic idle(input int n);
    s_valid = 0;
    s_last  = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  // mode 0: ramp k mod 256, mode 1: random pixels; gap_pct = chance of an idle beat
  task automatic send_frame(input int n, input int last_at, input int mode, input int gap_pct);
    for (int i = 0; i < n; i++) begin
      int guard;
      guard  = 0;
      s_data = (mode == 0) ? 8'(i % 256) : 8'($urandom);
      s_last = (i == last_at);
      do begin
        s_valid = (int'($urandom_range(99)) >= gap_pct);
        step();
        guard++;
      end while (!last_acc && guard < 5000);
      if (!last_acc) begin
        n_checks++;
        $display("FAIL beat_accept: beat %0d not accepted within %0d cycles", i, guard);
        n_print++;
        break;
      end
    end
    s_valid = 0;
    s_last  = 0;
  endtask

  typedef struct {
    logic [7:0] pix;
    logic [1:0] slot;
  } vec_t;
  vec_t tbl [8];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    tbl[0] = '{8'h00, 2'd0}; tbl[1] = '{8'h40, 2'd1};
    tbl[2] = '{8'h80, 2'd2}; tbl[3] = '{8'hFF, 2'd3};
    tbl[4] = '{8'h3F, 2'd0}; tbl[5] = '{8'hBF, 2'd2};
    tbl[6] = '{8'h7F, 2'd1}; tbl[7] = '{8'hC0, 2'd3};

    rst = 1; s_valid = 0; s_last = 0; s_data = '0; m_ready = 0;
    s2_valid = 0; s2_last = 0; s2_data = '0; m2_ready = 0;
    repeat (3) step();
    rst = 0;
    step();
    chk("ready_after_reset", 32'(s_ready), 32'd1);

    // Ramp image with a ready consumer: frame visible the cycle after the last beat
    m_ready = 1;
    e0 = err_seen;
    send_frame(NP, NP - 1, 0, 0);
    chk("ramp_latency", 32'(m_valid), 32'd1);
    chk("ramp_bit127", 32'(m_data[127]), 32'd0);
    chk("ramp_bit128", 32'(m_data[128]), 32'd1);
    chk("ramp_bit383", 32'(m_data[383]), 32'd0);
    chk("ramp_bit640", 32'(m_data[640]), 32'd1);
    idle(3);
    chk("ramp_no_err", 32'(err_seen - e0), 32'd0);

    // Three frames against a stalled consumer
    m_ready = 0;
    send_frame(NP, NP - 1, 1, 0);
    send_frame(NP, NP - 1, 1, 5);
    chk("ready_both_full", 32'(s_ready), 32'd0);
    idle(4);
    m_ready = 1;
    step();
    chk("ready_after_consume", 32'(s_ready), 32'd1);
    send_frame(NP, NP - 1, 1, 0);
    idle(4);

    // Short frame then a good one
    e0 = err_seen;
    send_frame(100, 99, 1, 0);
    idle(2);
    chk("short_no_valid", 32'(m_valid), 32'd0);
    send_frame(NP, NP - 1, 0, 0);
    idle(3);
    chk("short_err_count", 32'(err_seen - e0), 32'd1);

    // Long frame: first NP pixels committed, tail dropped, next frame aligned
    e0 = err_seen;
    send_frame(790, 789, 1, 0);
    send_frame(NP, NP - 1, 1, 10);
    idle(3);
    chk("long_err_count", 32'(err_seen - e0), 32'd1);

    // Reset while bank 0 is held full and bank 1 is half loaded
    rst = 1; step(); rst = 0; step();
    m_ready = 0;
    send_frame(NP, NP - 1, 0, 0);
    send_frame(400, -1, 1, 0);
    rst = 1;
    step();
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    rst = 0;
    step();
    m_ready = 1;
    send_frame(NP, NP - 1, 1, 0);
    idle(3);

    // Randomized traffic: gaps, random consumer, occasional bad lengths
    rand_mready = 1;
    for (int f = 0; f < 8; f++) begin
      int kind, len;
      kind = int'($urandom_range(9));
      if (kind == 0) len = int'($urandom_range(NP - 1, 1));
      else if (kind == 1) len = NP + int'($urandom_range(10, 1));
      else len = NP;
      send_frame(len, len - 1, 1, 20);
    end
    rand_mready = 0;
    m_ready = 1;
    idle(6);

    // IN_BITS=2 build, table-driven slot checks
    for (int g = 0; g < 2; g++) begin
      for (int k = 0; k < 4; k++) begin
        chk("s2_ready", 32'(s2_ready), 32'd1);
        s2_valid = 1;
        s2_data  = tbl[g * 4 + k].pix;
        s2_last  = (k == 3);
        step();
      end
      s2_valid = 0;
      s2_last  = 0;
      chk("s2_m_valid", 32'(m2_valid), 32'd1);
      chk("s2_err", 32'(err2), 32'd0);
      for (int k = 0; k < 4; k++) begin
        logic [7:0] d;
        d = m2_data;
        chk("s2_slot", 32'(d[k * 2 +: 2]), 32'(tbl[g * 4 + k].slot));
      end
      m2_ready = 1;
      step();
      m2_ready = 0;
      chk("s2_consumed", 32'(m2_valid), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ens0_input_packer.md
Name: ens0_input_packer

Overview:
Upstream feeder for ensemble 0, layer 0 of the MNIST-S LogicNet. Accepts a raw pixel stream one pixel per beat over a valid/ready handshake and quantizes each pixel to IN_BITS. Packs one image into a flat frame vector whose fan-out slices drive the layer-0 neuron LUT inputs. Double-buffered: the next image loads while the previous frame is held stable for layer 0.

Parameters:
NUM_PIXELS, 784, pixels per image (frame length)
PIX_W, 8, raw pixel width
IN_BITS, 1, quantized bits per pixel (1..PIX_W)
FRAME_W, NUM_PIXELS*IN_BITS, packed frame width (derived, not overridable)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
s_valid  input  1  pixel beat valid
s_ready  output  1  packer can accept a pixel
s_data  input  PIX_W  raw unsigned pixel
s_last  input  1  marks the final pixel of an image
m_valid  output  1  packed frame available
m_ready  input  1  layer 0 consumes frame
m_data  output  FRAME_W  packed frame; pixel k at bits [k*IN_BITS +: IN_BITS]
err_len  output  1  one-cycle pulse on frame length error

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset, all registered: s_ready=0 for the reset cycle, then 1 from the first cycle after rst deasserts. m_valid=0, err_len=0, both banks empty, write bank=0, read bank=0, pixel count=0, state=FILL. m_data contents are don't-care while m_valid=0.
- Quantization: q = s_data >> (PIX_W-IN_BITS). Truncation only, no rounding. For IN_BITS=1, q = s_data[7].
- Transfer occurs when s_valid && s_ready. The quantized value is written into the write bank at the slot given by the pixel count. Count increments by 1.
- s_ready = (state==DISCARD) || (write bank empty). It is registered and updates the cycle after a bank is freed or filled.
- State FILL:
  - Accept with count<NUM_PIXELS-1 and s_last=1 (short frame): pulse err_len. Count resets to 0. Bank is not committed and the partial data is dropped. Stay in FILL.
  - Accept with count==NUM_PIXELS-1: commit the bank (full), toggle the write bank, reset count to 0.
    - If s_last=1: stay in FILL.
    - If s_last=0 (long frame): still commit, pulse err_len, go to DISCARD.
- State DISCARD: accept and drop every beat, ignoring bank state. A beat with s_last=1 returns the block to FILL.
- Read side:
  - m_valid = read bank full. m_data is driven from the read bank and held stable while m_valid=1 and !m_ready.
  - On m_valid && m_ready: free the read bank and toggle the read bank next cycle.
- Latency: last pixel accepted in cycle T, with the target read bank empty, gives m_valid=1 at T+1.
- Throughput: one pixel per cycle sustained. Back-to-back frames stall only when both banks are full.
- Simultaneous events:
  - Commit of one bank and consume of the other in the same cycle are both honoured.
  - Consume of bank A in cycle T makes bank A writable from T+1; s_ready rises at T+1.
- Both banks full: s_ready=0 and s_data is ignored. Count is not disturbed.
- Reset mid-frame or mid-hold discards all buffered data and returns to the reset state above; no err_len pulse.
- Count width is $clog2(NUM_PIXELS). Count never exceeds NUM_PIXELS-1 and does not wrap silently.

Decomposition:
- Shared package ens_pkg holds NUM_PIXELS, PIX_W, IN_BITS, FRAME_W, the FILL/DISCARD state enum, and the quantize function. Layer-0 wrappers import the same FRAME_W and slice map.
- One natural sub-module, ens0_frame_bank: a FRAME_W register with slot-write (index, data, we) and full/free flags. It is instantiated twice. The top level holds the FSM, counter, bank pointers and handshakes.

Test Plan:
- Ramp image (pixel k = k mod 256), s_last on beat 783, m_ready=1 → m_valid at T+1. m_data bit k = (k mod 256)>=128; no err_len.
- Three back-to-back frames, m_ready=0 → frames 1 and 2 buffered. s_ready drops after frame 2's last beat. Raise m_ready: frames emerge in order; s_ready returns the cycle after the first consume.
- Short frame with s_last at beat 99, then a valid 784-beat frame → one err_len pulse at beat 99, no m_valid for the short frame. The second frame is output intact.
- Long frame, 790 beats with s_last on 790 → frame of first 784 pixels committed, err_len pulse on beat 784, beats 785-790 dropped. The next frame is aligned.
- rst asserted at beat 400 while bank 0 is held full → m_valid=0 and s_ready=0 the cycle after rst. A fresh frame loads into bank 0 correctly.
- IN_BITS=2 build, pixels 0x00/0x40/0x80/0xFF → 2-bit slots 0,1,2,3 at bits [1:0],[3:2],[5:4],[7:6].
